// File: rtl/coproc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coproc_pkg
//  Description : Shared constants, opcodes and sequencer state encoding for
//                the matrix coprocessor.
//  Revision    : 1.0 - initial release
// ============================================================================
package coproc_pkg;

    // Matrix geometry fixed by the ALU operand bus format
    localparam int N_ELEM = 25;
    localparam int ELEM_W = 8;
    localparam int OPC_W  = 4;
    localparam int CNT_W  = $clog2(N_ELEM);

    // ALU opcodes known to the coprocessor (others are passed through untouched)
    localparam logic [OPC_W-1:0] OP_ADD = 4'd3;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_A   = 3'd1,
        ST_LOAD_B   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_EXEC     = 3'd4,
        ST_WAIT_CLR = 3'd5,
        ST_STORE    = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // True in the states that walk the element counter
    function automatic logic is_stream_state(input state_t s);
        return (s == ST_LOAD_A) || (s == ST_LOAD_B) || (s == ST_STORE);
    endfunction

endpackage : coproc_pkg
`default_nettype wire

// File: rtl/matrix_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_fetch_ctrl
//  Description : Coprocessor sequencer in front of the matrix ALU. Fetches
//                operands A and B byte-wise, packs them onto the ALU buses,
//                runs the start/done handshake and writes the result back.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_fetch_ctrl
    import coproc_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int ELEM_W = coproc_pkg::ELEM_W,
    parameter int N_ELEM = coproc_pkg::N_ELEM
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [3:0]                 instr_opcode,
    input  logic [7:0]                 instr_escalar,
    input  logic [ADDR_W-1:0]          addr_a,
    input  logic [ADDR_W-1:0]          addr_b,
    input  logic [ADDR_W-1:0]          addr_c,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd,
    input  logic [ELEM_W-1:0]          mem_rdata,
    output logic                       mem_wr,
    output logic [ELEM_W-1:0]          mem_wdata,
    output logic                       ula_start,
    output logic [3:0]                 ula_opcode,
    output logic [7:0]                 ula_escalar,
    output logic [N_ELEM*ELEM_W-1:0]   matriz_a,
    output logic [N_ELEM*ELEM_W-1:0]   matriz_b,
    input  logic                       ula_done,
    input  logic [N_ELEM*ELEM_W-1:0]   matriz_resultante,
    output logic                       busy,
    output logic                       op_done
);

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N_ELEM - 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    k;
    logic                k_last;
    logic                accept;

    logic [ADDR_W-1:0]   base_a;
    logic [ADDR_W-1:0]   base_b;
    logic [ADDR_W-1:0]   base_c;

    // Tag of the read issued in the previous cycle; its data arrives now
    logic                cap_valid;
    logic                cap_is_b;
    logic [CNT_W-1:0]    cap_idx;

    logic [ELEM_W-1:0]   a_elem [N_ELEM];
    logic [ELEM_W-1:0]   b_elem [N_ELEM];
    logic [ELEM_W-1:0]   r_elem [N_ELEM];

    assign k_last = (k == K_LAST);
    assign accept = instr_valid && instr_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode and Moore outputs
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        busy        = 1'b1;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        ula_start   = 1'b0;
        op_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) state_next = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                mem_rd   = 1'b1;
                mem_addr = base_a + ADDR_W'(k);
                if (k_last) state_next = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                mem_rd   = 1'b1;
                mem_addr = base_b + ADDR_W'(k);
                if (k_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                ula_start = 1'b1;
                if (ula_done) state_next = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                // The ALU only drops done once it sees start low
                if (!ula_done) state_next = ST_STORE;
            end
            ST_STORE: begin
                mem_wr    = 1'b1;
                mem_addr  = base_c + ADDR_W'(k);
                mem_wdata = r_elem[k];
                if (k_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                op_done    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Element counter shared by both load phases and the store phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (accept) begin
            k <= '0;
        end else if (is_stream_state(state)) begin
            k <= k_last ? '0 : k + CNT_W'(1);
        end
    end

    // Instruction fields latched on accept and held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ula_opcode  <= '0;
            ula_escalar <= '0;
            base_a      <= '0;
            base_b      <= '0;
            base_c      <= '0;
        end else if (accept) begin
            ula_opcode  <= instr_opcode;
            ula_escalar <= instr_escalar;
            base_a      <= addr_a;
            base_b      <= addr_b;
            base_c      <= addr_c;
        end
    end

    // Read-data capture, one cycle behind the issuing read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= 1'b0;
            cap_is_b  <= 1'b0;
            cap_idx   <= '0;
            for (int i = 0; i < N_ELEM; i++) begin
                a_elem[i] <= '0;
                b_elem[i] <= '0;
            end
        end else begin
            cap_valid <= mem_rd;
            cap_is_b  <= (state == ST_LOAD_B);
            cap_idx   <= k;
            if (cap_valid) begin
                if (cap_is_b) b_elem[cap_idx] <= mem_rdata;
                else          a_elem[cap_idx] <= mem_rdata;
            end
        end
    end

    // Result snapshot taken when the ALU reports done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEM; i++) r_elem[i] <= '0;
        end else if ((state == ST_EXEC) && ula_done) begin
            for (int i = 0; i < N_ELEM; i++)
                r_elem[i] <= matriz_resultante[i*ELEM_W +: ELEM_W];
        end
    end

    // Pack element k onto bits [ELEM_W*k +: ELEM_W] of each operand bus
    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_pack
            assign matriz_a[gi*ELEM_W +: ELEM_W] = a_elem[gi];
            assign matriz_b[gi*ELEM_W +: ELEM_W] = b_elem[gi];
        end
    endgenerate

endmodule : matrix_fetch_ctrl
`default_nettype wire

// File: tb/tb_matrix_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_fetch_ctrl
//  Description : Self-checking bench for matrix_fetch_ctrl with a byte memory,
//                a parameterisable-latency ALU stand-in and a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_fetch_ctrl;

    localparam int AW = 9;
    localparam int NE = 25;
    localparam int BW = 200;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            instr_valid;
    logic            instr_ready;
    logic [3:0]      instr_opcode;
    logic [7:0]      instr_escalar;
    logic [AW-1:0]   addr_a, addr_b, addr_c;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd, mem_wr;
    logic [7:0]      mem_rdata = 8'h00;
    logic [7:0]      mem_wdata;
    logic            ula_start;
    logic [3:0]      ula_opcode;
    logic [7:0]      ula_escalar;
    logic [BW-1:0]   matriz_a, matriz_b;
    logic            ula_done = 1'b0;
    logic [BW-1:0]   matriz_resultante = '0;
    logic            busy, op_done;

    always #5 clk = ~clk;

    matrix_fetch_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr_opcode      (instr_opcode),
        .instr_escalar     (instr_escalar),
        .addr_a            (addr_a),
        .addr_b            (addr_b),
        .addr_c            (addr_c),
        .mem_addr          (mem_addr),
        .mem_rd            (mem_rd),
        .mem_rdata         (mem_rdata),
        .mem_wr            (mem_wr),
        .mem_wdata         (mem_wdata),
        .ula_start         (ula_start),
        .ula_opcode        (ula_opcode),
        .ula_escalar       (ula_escalar),
        .matriz_a          (matriz_a),
        .matriz_b          (matriz_b),
        .ula_done          (ula_done),
        .matriz_resultante (matriz_resultante),
        .busy              (busy),
        .op_done           (op_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference operands written into memory for the current operation
    logic [7:0] ea [NE];
    logic [7:0] eb [NE];

    // Elementwise ALU rule: add for opcode 3, xor for anything else
    function automatic logic [7:0] ref_elem(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return (op == 4'd3) ? 8'(a + b) : (a ^ b);
    endfunction

    // ---------------- byte memory, one-cycle read latency ----------------
    logic [7:0] mem [512];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] = mem_wdata;
    end

    // ---------------- ALU stand-in with programmable delay ---------------
    int alu_delay = 0;
    int alu_cnt   = 0;
    always @(posedge clk) begin
        if (!ula_start) begin
            ula_done <= 1'b0;
            alu_cnt  <= 0;
        end else if (!ula_done) begin
            if (alu_cnt >= alu_delay) begin
                ula_done <= 1'b1;
                for (int i = 0; i < NE; i++)
                    matriz_resultante[i*8 +: 8] <= ref_elem(ula_opcode, matriz_a[i*8 +: 8], matriz_b[i*8 +: 8]);
            end else begin
                alu_cnt <= alu_cnt + 1;
            end
        end
    end

    // ---------------- bus monitor ----------------------------------------
    int cyc = 0, last_acc = 0, acc_count = 0, wr_cnt = 0, done_cnt = 0, clash = 0;
    logic [AW-1:0] rd_log [$];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (instr_valid && instr_ready) begin
            last_acc  = cyc;
            acc_count = acc_count + 1;
        end
        if (mem_rd) rd_log.push_back(mem_addr);
        if (mem_wr) wr_cnt = wr_cnt + 1;
        if (op_done) done_cnt = done_cnt + 1;
        if (mem_rd && mem_wr) clash = clash + 1;
        if (instr_ready && busy) clash = clash + 1;
    end

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fill A/B regions per pattern and poison the C region
    task automatic setup(input int mode, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
        for (int i = 0; i < NE; i++) begin
            case (mode)
                0:       begin ea[i] = 8'(i);         eb[i] = 8'(2 * i);      end
                1:       begin ea[i] = 8'h90;         eb[i] = 8'h90;          end
                default: begin ea[i] = 8'($urandom);  eb[i] = 8'($urandom);   end
            endcase
            mem[AW'(a + i)] = ea[i];
            mem[AW'(b + i)] = eb[i];
            mem[AW'(c + i)] = 8'hEE;
        end
    endtask

    task automatic clear_mon();
        rd_log.delete();
        wr_cnt = 0; done_cnt = 0; clash = 0;
    endtask

    // Present an instruction and wait (bounded) for it to be accepted
    task automatic issue(input logic [3:0] op, input logic [7:0] esc, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [AW-1:0] c, input bit hold);
        int n0;
        @(negedge clk);
        n0 = acc_count;
        instr_opcode = op; instr_escalar = esc;
        addr_a = a; addr_b = b; addr_c = c;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && acc_count == n0; i++) @(negedge clk);
        chk("accept", BW'(acc_count != n0), BW'(1));
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        for (int i = 0; i < 400 && !op_done; i++) @(negedge clk);
        chk("op_done_seen", BW'(op_done), BW'(1));
        lat = cyc - last_acc;
    endtask

    task automatic verify(input string tag, input logic [3:0] op, input logic [7:0] esc,
                          input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                          input int lat, input int exp_lat);
        logic [BW-1:0] pa, pb;
        int bad_rd, bad_c;
        chk({tag, ":latency"}, BW'(lat), BW'(exp_lat));
        bad_rd = 0;
        for (int i = 0; i < 2 * NE && i < rd_log.size(); i++) begin
            if (rd_log[i] !== ((i < NE) ? AW'(a + i) : AW'(b + i - NE))) bad_rd++;
        end
        chk({tag, ":rd_count"}, BW'(rd_log.size()), BW'(2 * NE));
        chk({tag, ":rd_addr_bad"}, BW'(bad_rd), BW'(0));
        for (int i = 0; i < NE; i++) begin
            pa[i*8 +: 8] = ea[i];
            pb[i*8 +: 8] = eb[i];
        end
        chk({tag, ":matriz_a"}, matriz_a, pa);
        chk({tag, ":matriz_b"}, matriz_b, pb);
        chk({tag, ":ula_opcode"}, BW'(ula_opcode), BW'(op));
        chk({tag, ":ula_escalar"}, BW'(ula_escalar), BW'(esc));
        @(negedge clk);
        @(negedge clk);
        bad_c = 0;
        for (int i = 0; i < NE; i++)
            if (mem[AW'(c + i)] !== ref_elem(op, ea[i], eb[i])) bad_c++;
        chk({tag, ":c_bytes_bad"}, BW'(bad_c), BW'(0));
        chk({tag, ":c_first"}, BW'(mem[c]), BW'(ref_elem(op, ea[0], eb[0])));
        chk({tag, ":wr_count"}, BW'(wr_cnt), BW'(NE));
        chk({tag, ":op_done_pulses"}, BW'(done_cnt), BW'(1));
        chk({tag, ":protocol_clash"}, BW'(clash), BW'(0));
        chk({tag, ":idle_after"}, BW'({instr_ready, busy}), BW'(2'b10));
    endtask

    task automatic run_op(input string tag, input int mode, input logic [3:0] op, input logic [7:0] esc,
                          input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c, input int dly);
        int lat;
        setup(mode, a, b, c);
        alu_delay = dly;
        clear_mon();
        issue(op, esc, a, b, c, 1'b0);
        wait_done(lat);
        verify(tag, op, esc, a, b, c, lat, 80 + dly);
    endtask

    initial begin
        int lat, first_acc, n0, bad_c;
        logic [AW-1:0] ra;
        logic [3:0] rop;
        rst_n = 1'b0; instr_valid = 1'b0; instr_opcode = '0; instr_escalar = '0;
        addr_a = '0; addr_b = '0; addr_c = '0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        #1;
        chk("reset:outputs_zero", {mem_rd, mem_wr, mem_addr, mem_wdata, ula_start, op_done, busy,
                                   ula_opcode, ula_escalar}, '0);
        chk("reset:matriz_a", matriz_a, '0);
        chk("reset:instr_ready", BW'(instr_ready), BW'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("add",      0, 4'd3, 8'h11, 9'h000, 9'h040, 9'h080, 0);
        run_op("overflow", 1, 4'd3, 8'h00, 9'h000, 9'h040, 9'h080, 0);
        run_op("wrap",     0, 4'd3, 8'h05, 9'h1F0, 9'h020, 9'h100, 0);
        run_op("slow_alu", 2, 4'd3, 8'h7E, 9'h010, 9'h060, 9'h0C0, 9);

        // Randomised operations, including an unknown opcode passed through
        for (int t = 0; t < 3; t++) begin
            ra  = AW'($urandom_range(0, 511));
            rop = (t == 1) ? 4'hB : 4'd3;
            run_op("random", 2, rop, 8'($urandom), ra, AW'(ra + 64), AW'(ra + 192), $urandom_range(0, 4));
        end

        // Back-to-back: valid held high across the whole first operation
        setup(2, 9'h000, 9'h040, 9'h080);
        alu_delay = 0;
        clear_mon();
        issue(4'd3, 8'h01, 9'h000, 9'h040, 9'h080, 1'b1);
        first_acc = last_acc;
        wait_done(lat);
        chk("b2b:latency", BW'(lat), BW'(80));
        n0 = acc_count;
        for (int i = 0; i < 20 && acc_count == n0; i++) @(negedge clk);
        chk("b2b:second_accept_gap", BW'(last_acc - first_acc), BW'(82));
        instr_valid = 1'b0;
        wait_done(lat);
        repeat (2) @(negedge clk);
        chk("b2b:op_done_pulses", BW'(done_cnt), BW'(2));
        chk("b2b:protocol_clash", BW'(clash), BW'(0));
        chk("b2b:accepts", BW'(acc_count - n0), BW'(1));

        // Reset while storing element 10
        setup(0, 9'h000, 9'h040, 9'h080);
        clear_mon();
        issue(4'd3, 8'h22, 9'h000, 9'h040, 9'h080, 1'b0);
        for (int i = 0; i < 200 && !(mem_wr && mem_addr == 9'h08A); i++) @(negedge clk);
        chk("rst_mid:reached_k10", BW'(mem_wr && mem_addr == 9'h08A), BW'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid:outputs_zero", {mem_rd, mem_wr, mem_addr, mem_wdata, ula_start, op_done, busy}, '0);
        chk("rst_mid:instr_ready", BW'(instr_ready), BW'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_mid:wr_count", BW'(wr_cnt), BW'(10));
        bad_c = 0;
        for (int i = 0; i < 10; i++) if (mem[AW'(9'h080 + i)] !== 8'(3 * i)) bad_c++;
        chk("rst_mid:written_bytes_bad", BW'(bad_c), BW'(0));
        chk("rst_mid:byte10_untouched", BW'(mem[9'h08A]), BW'(8'hEE));
        chk("rst_mid:idle", BW'({instr_ready, busy}), BW'(2'b10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_matrix_fetch_ctrl
`default_nettype wire
